div_issue_ctrl: RTL and testbench
=================================

// Module: div_issue_ctrl
// PURPOSE
//  Sequences the iterative divider between the EX stage and HI/LO for DIV/DIVU.
//  Latches operands and signedness, then holds div_start and the operands stable until div_ready.
//  Stalls the pipeline while the divide runs and writes {HI,LO} exactly once.
//  On a pipeline flush it drains the divider safely and discards the result.
// PARAMETERS
//  TIMEOUT  64  max cycles in BUSY/DRAIN before forced abort (watchdog); must exceed divider latency (~20)
//  TO_W     7   width of watchdog counter; 2**TO_W > TIMEOUT
// PORTS
//  cpu_clk_75M    in   1   single clock, all state on rising edge
//  cpu_rst_n      in   1   reset, asynchronous, active-low
//  ex_div_req     in   1   EX holds a DIV/DIVU this cycle (level; held while stall_req=1)
//  ex_div_signed  in   1   1=DIV, 0=DIVU
//  ex_opdata1     in   32  dividend (rs)
//  ex_opdata2     in   32  divisor (rt)
//  flush_i        in   1   exception/flush: cancel any in-flight divide
//  div_start      out  1   to divider; 1=DivStart, 0=DivStop
//  signed_div_o   out  1   to divider signed_div_i
//  div_opdata1_o  out  32  to divider, registered, stable for whole operation
//  div_opdata2_o  out  32  to divider, registered, stable for whole operation
//  div_result_i   in   64  from divider {remainder,quotient}
//  div_ready_i    in   1   from divider, result valid
//  stall_req      out  1   pipeline stall request
//  hilo_we        out  1   one-cycle HI/LO write strobe
//  hi_o           out  32  remainder, valid with hilo_we
//  lo_o           out  32  quotient, valid with hilo_we
//  div_err        out  1   one-cycle pulse on watchdog abort
// BEHAVIOUR
//  Reset values: state=IDLE; all outputs 0; watchdog=0. Reset mid-operation returns to IDLE at once.
//  FSM states: IDLE, BUSY, RELEASE, DRAIN.
//  IDLE:
//   - ex_div_req & ~flush_i: latch operands/sign into output regs, div_start<=1, go BUSY.
//   - stall_req is combinationally 1 in the request cycle: stall_req = (IDLE & ex_div_req & ~flush_i) | BUSY.
//   - flush_i & ex_div_req: ignore the request, stay IDLE.
//  BUSY:
//   - operand/sign regs frozen; watchdog increments each cycle.
//   - div_ready_i & ~flush_i: hi_o<=div_result_i[63:32], lo_o<=div_result_i[31:0], hilo_we<=1 (next cycle,
//     one cycle only), div_start<=0, go RELEASE. stall_req drops in the same cycle hilo_we rises.
//   - flush_i (with or without div_ready_i): no write, stall_req=0 from next cycle.
//     If div_ready_i is also high: div_start<=0, go RELEASE. Otherwise go DRAIN with div_start held 1,
//     because the divider ignores DivStop until it finishes.
//   - watchdog==TIMEOUT: div_start<=0, div_err pulse, go RELEASE, no write.
//  RELEASE: one cycle with div_start=0 so the divider returns to its free state; ex_div_req is ignored.
//   Next state IDLE. Back-to-back divides are therefore spaced by at least 1 idle cycle.
//  DRAIN: stall_req=0; new requests are not accepted (ex_div_req ignored).
//   On div_ready_i or watchdog==TIMEOUT: div_start<=0, go RELEASE, result discarded. Further flush_i has no effect.
//  Watchdog clears on every entry to BUSY or DRAIN.
//  Divide by zero needs no special case: the divider returns 0, so HI=LO=0 are written.
//  hilo_we is never asserted outside the cycle after a BUSY->RELEASE transition caused by div_ready_i.
//  hi_o/lo_o hold their last written values between writes.
// TESTING
//  1 DIVU 100/7: hilo_we once, hi=2, lo=14; stall_req high from request cycle until the write cycle.
//  2 DIV 0xFFFFFFF9(-7)/2: lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 7/0xFFFFFFFE: lo=0xFFFFFFFD, hi=1.
//  3 DIVU 5/0: hilo_we with hi=0, lo=0; no div_err.
//  4 flush_i 5 cycles into BUSY: no hilo_we; stall_req low next cycle; DRAIN until div_ready_i; div_start
//    falls after div_ready_i; a request issued during DRAIN is accepted only after RELEASE.
//  5 Back-to-back DIVU 9/3 then 10/4 with ex_div_req held: writes (0,3) then (2,2); div_start low >=1 cycle
//    between operations; operands unchanged while BUSY even if ex_opdata* toggle.
//  6 cpu_rst_n low mid-BUSY: all outputs 0 asynchronously. Divider model stuck (no ready): div_err
//    after TIMEOUT cycles, no hilo_we.

Source files
------------

// File: rtl/div_issue_ctrl.sv
// Issue controller for the iterative divider: latches DIV/DIVU operands, stalls EX
// until {HI,LO} is written once, and drains the divider safely on a pipeline flush.
module div_issue_ctrl #(
  parameter int TIMEOUT = 64,
  parameter int TO_W    = 7
) (
  input  logic        cpu_clk_75M,
  input  logic        cpu_rst_n,
  input  logic        ex_div_req,
  input  logic        ex_div_signed,
  input  logic [31:0] ex_opdata1,
  input  logic [31:0] ex_opdata2,
  input  logic        flush_i,
  output logic        div_start,
  output logic        signed_div_o,
  output logic [31:0] div_opdata1_o,
  output logic [31:0] div_opdata2_o,
  input  logic [63:0] div_result_i,
  input  logic        div_ready_i,
  output logic        stall_req,
  output logic        hilo_we,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        div_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2,
    DRAIN   = 2'd3
  } state_e;

  localparam logic [TO_W-1:0] TO_VAL = TO_W'(TIMEOUT);

  state_e          state_q, state_d;
  logic [TO_W-1:0] wd_q, wd_d;
  logic            div_start_q, div_start_d;
  logic            sign_q, sign_d;
  logic [31:0]     op1_q, op1_d;
  logic [31:0]     op2_q, op2_d;
  logic            we_q, we_d;
  logic [31:0]     hi_q, hi_d;
  logic [31:0]     lo_q, lo_d;
  logic            err_q, err_d;
  logic            timeout;
  logic            accept;
  logic            stall_raw;

  assign timeout = (wd_q == TO_VAL);
  assign accept  = (state_q == IDLE) && ex_div_req && !flush_i;

  always_ff @(posedge cpu_clk_75M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) state_d = BUSY;
      end
      BUSY: begin
        // A ready result always ends BUSY; a flush without it must wait in DRAIN.
        if (div_ready_i)  state_d = RELEASE;
        else if (flush_i) state_d = DRAIN;
        else if (timeout) state_d = RELEASE;
      end
      RELEASE: state_d = IDLE;
      DRAIN: begin
        if (div_ready_i || timeout) state_d = RELEASE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    div_start_d = div_start_q;
    sign_d      = sign_q;
    op1_d       = op1_q;
    op2_d       = op2_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    we_d        = 1'b0;
    err_d       = 1'b0;
    wd_d        = wd_q;
    stall_raw   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          stall_raw   = 1'b1;
          sign_d      = ex_div_signed;
          op1_d       = ex_opdata1;
          op2_d       = ex_opdata2;
          div_start_d = 1'b1;
          wd_d        = '0;
        end
      end
      BUSY: begin
        stall_raw = 1'b1;
        wd_d      = wd_q + 1'b1;
        if (div_ready_i) begin
          div_start_d = 1'b0;
          if (!flush_i) begin
            we_d = 1'b1;
            hi_d = div_result_i[63:32];
            lo_d = div_result_i[31:0];
          end
        end else if (flush_i) begin
          // div_start stays high: the divider only honours DivStop once it finishes.
          wd_d = '0;
        end else if (timeout) begin
          div_start_d = 1'b0;
          err_d       = 1'b1;
        end
      end
      DRAIN: begin
        wd_d = wd_q + 1'b1;
        if (div_ready_i || timeout) begin
          div_start_d = 1'b0;
          err_d       = !div_ready_i;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge cpu_clk_75M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      wd_q        <= '0;
      div_start_q <= 1'b0;
      sign_q      <= 1'b0;
      op1_q       <= '0;
      op2_q       <= '0;
      we_q        <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
      err_q       <= 1'b0;
    end else begin
      wd_q        <= wd_d;
      div_start_q <= div_start_d;
      sign_q      <= sign_d;
      op1_q       <= op1_d;
      op2_q       <= op2_d;
      we_q        <= we_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      err_q       <= err_d;
    end
  end

  // The request-cycle stall is combinational, so it is masked while reset is held.
  assign stall_req     = stall_raw && cpu_rst_n;
  assign div_start     = div_start_q;
  assign signed_div_o  = sign_q;
  assign div_opdata1_o = op1_q;
  assign div_opdata2_o = op2_q;
  assign hilo_we       = we_q;
  assign hi_o          = hi_q;
  assign lo_o          = lo_q;
  assign div_err       = err_q;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Bench for div_issue_ctrl: behavioural divider, vector table, flush/drain,
// back-to-back, watchdog and reset sequences, plus randomized operations.
module tb_div_issue_ctrl;

  localparam int TIMEOUT = 64;
  localparam int BOUND   = 200;

  logic        cpu_clk_75M = 1'b0;
  logic        cpu_rst_n;
  logic        ex_div_req;
  logic        ex_div_signed;
  logic [31:0] ex_opdata1;
  logic [31:0] ex_opdata2;
  logic        flush_i;
  logic        div_start;
  logic        signed_div_o;
  logic [31:0] div_opdata1_o;
  logic [31:0] div_opdata2_o;
  logic [63:0] div_result_i;
  logic        div_ready_i;
  logic        stall_req;
  logic        hilo_we;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        div_err;

  int n_chk  = 0;
  int n_pass = 0;
  int div_lat;
  bit div_stuck;

  div_issue_ctrl #(.TIMEOUT(TIMEOUT), .TO_W(7)) dut (
    .cpu_clk_75M  (cpu_clk_75M),
    .cpu_rst_n    (cpu_rst_n),
    .ex_div_req   (ex_div_req),
    .ex_div_signed(ex_div_signed),
    .ex_opdata1   (ex_opdata1),
    .ex_opdata2   (ex_opdata2),
    .flush_i      (flush_i),
    .div_start    (div_start),
    .signed_div_o (signed_div_o),
    .div_opdata1_o(div_opdata1_o),
    .div_opdata2_o(div_opdata2_o),
    .div_result_i (div_result_i),
    .div_ready_i  (div_ready_i),
    .stall_req    (stall_req),
    .hilo_we      (hilo_we),
    .hi_o         (hi_o),
    .lo_o         (lo_o),
    .div_err      (div_err)
  );

  always #5 cpu_clk_75M = ~cpu_clk_75M;

  // MIPS divide semantics: truncate toward zero, remainder takes dividend's sign; x/0 gives 0.
  function automatic logic [63:0] ref_div(input bit s, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa - q * sb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %0h required %0h", nm, act, exp);
  endtask

  // Divider: starts on div_start from its free state, answers after div_lat cycles,
  // then waits for DivStop before accepting another operation.
  initial begin : divider_model
    bit busy, done, os;
    int cnt;
    logic [31:0] oa, ob;
    busy = 0; done = 0; cnt = 0; os = 0; oa = '0; ob = '0;
    div_ready_i  = 1'b0;
    div_result_i = '0;
    forever begin
      @(posedge cpu_clk_75M);
      #1;
      div_ready_i = 1'b0;
      if (!cpu_rst_n) begin
        busy = 0; done = 0;
      end else if (busy) begin
        cnt++;
        if (!div_stuck && cnt >= div_lat) begin
          div_ready_i  = 1'b1;
          div_result_i = ref_div(os, oa, ob);
          busy = 0; done = 1;
        end
      end else if (done) begin
        if (!div_start) done = 0;
      end else if (div_start) begin
        busy = 1; cnt = 0;
        os = signed_div_o; oa = div_opdata1_o; ob = div_opdata2_o;
      end
    end
  end

  task automatic check_reset_vals(input string nm);
    chk({nm, "_ctrl"}, {div_start, signed_div_o, stall_req, hilo_we, div_err}, 64'd0);
    chk({nm, "_ops"}, {div_opdata1_o, div_opdata2_o}, 64'd0);
    chk({nm, "_hilo"}, {hi_o, lo_o}, 64'd0);
  endtask

  task automatic do_reset();
    @(negedge cpu_clk_75M);
    cpu_rst_n = 1'b0; ex_div_req = 1'b0; flush_i = 1'b0;
    repeat (2) @(negedge cpu_clk_75M);
    cpu_rst_n = 1'b1;
  endtask

  task automatic idle_cycles(input int k);
    for (int i = 0; i < k; i++) begin
      @(negedge cpu_clk_75M);
      ex_div_req = 1'b0; flush_i = 1'b0;
      #1;
      if (i == 0) chk("idle_we_pulse", hilo_we, 64'd0);
    end
  endtask

  // One full divide from the request cycle to the HI/LO write cycle.
  task automatic do_div(input bit s, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input bit toggle, input string nm);
    bit stall_ok, frz_ok, err_seen, done;
    stall_ok = 1; frz_ok = 1; err_seen = 0; done = 0;
    for (int n = 0; n < BOUND; n++) begin
      @(negedge cpu_clk_75M);
      if (n == 0) begin
        ex_div_req = 1'b1; ex_div_signed = s; ex_opdata1 = a; ex_opdata2 = b; flush_i = 1'b0;
      end else if (toggle) begin
        ex_opdata1 = $urandom; ex_opdata2 = $urandom; ex_div_signed = 1'($urandom_range(0, 1));
      end
      #1;
      if (n == 0) chk({nm, "_gap"}, {hilo_we, div_start}, 64'd0);
      if (div_err) err_seen = 1;
      if (hilo_we) begin
        done = 1;
        chk({nm, "_stall_drop"}, stall_req, 64'd0);
        chk({nm, "_hilo"}, {hi_o, lo_o}, exp);
        break;
      end
      if (!stall_req) stall_ok = 0;
      if (div_start && ({signed_div_o, div_opdata1_o, div_opdata2_o} !== {s, a, b})) frz_ok = 0;
    end
    chk({nm, "_write"}, done, 64'd1);
    chk({nm, "_stall"}, stall_ok, 64'd1);
    chk({nm, "_frozen"}, frz_ok, 64'd1);
    chk({nm, "_no_err"}, err_seen, 64'd0);
  endtask

  // Divide flushed fat cycles after acceptance; ends in the cycle div_start falls.
  task automatic do_flush(input bit s, input logic [31:0] a, input logic [31:0] b,
                          input int fat, input string nm);
    bit stall_ok, quiet;
    int rdy_n, low_n;
    stall_ok = 1; quiet = 1; rdy_n = -1; low_n = -1;
    for (int n = 0; n < BOUND; n++) begin
      @(negedge cpu_clk_75M);
      if (n == 0) begin
        ex_div_req = 1'b1; ex_div_signed = s; ex_opdata1 = a; ex_opdata2 = b; flush_i = 1'b0;
      end else if (n == fat) begin
        flush_i = 1'b1; ex_div_req = 1'b0;
      end else begin
        flush_i = 1'b0;
      end
      #1;
      if (hilo_we || div_err) quiet = 0;
      if (n <= fat) begin
        if (!stall_req) stall_ok = 0;
      end else if (stall_req) stall_ok = 0;
      if (n >= fat && div_ready_i && rdy_n < 0) rdy_n = n;
      if (n > fat && !div_start) begin
        low_n = n;
        break;
      end
    end
    chk({nm, "_quiet"}, quiet, 64'd1);
    chk({nm, "_stall"}, stall_ok, 64'd1);
    chk({nm, "_start_fall"}, low_n, rdy_n + 1);
  endtask

  typedef struct {
    bit          s;
    logic [31:0] a;
    logic [31:0] b;
    int          lat;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[8];

  initial begin : watchdog
    #3000000;
    $display("FAIL global_timeout: actual running required finished");
    $fatal(1);
  end

  initial begin : main
    bit quiet, stall_ok, frz_ok;
    int rdy_n, low_n, err_n;

    vecs[0] = '{1'b0, 32'd100,        32'd7,          12, 32'd2,        32'd14};
    vecs[1] = '{1'b1, 32'hFFFFFFF9,   32'd2,          5,  32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[2] = '{1'b1, 32'd7,          32'hFFFFFFFE,   20, 32'd1,        32'hFFFFFFFD};
    vecs[3] = '{1'b0, 32'd5,          32'd0,          8,  32'd0,        32'd0};
    vecs[4] = '{1'b0, 32'hFFFFFFFF,   32'd1,          1,  32'd0,        32'hFFFFFFFF};
    vecs[5] = '{1'b1, 32'h80000000,   32'd2,          3,  32'd0,        32'hC0000000};
    vecs[6] = '{1'b1, 32'hFFFFFF9C,   32'd7,          15, 32'hFFFFFFFE, 32'hFFFFFFF2};
    vecs[7] = '{1'b0, 32'hFFFFFFFF,   32'd10,         25, 32'd5,        32'h19999999};

    cpu_rst_n = 1'b0; ex_div_req = 1'b0; ex_div_signed = 1'b0;
    ex_opdata1 = '0; ex_opdata2 = '0; flush_i = 1'b0;
    div_lat = 4; div_stuck = 0;
    repeat (3) @(negedge cpu_clk_75M);
    #1;
    check_reset_vals("reset");
    @(negedge cpu_clk_75M);
    cpu_rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      div_lat = vecs[i].lat;
      do_div(vecs[i].s, vecs[i].a, vecs[i].b, {vecs[i].hi, vecs[i].lo}, 1'b0, $sformatf("vec%0d", i));
      idle_cycles(1);
    end

    // Flush mid-BUSY, then a request raised during DRAIN must wait for RELEASE.
    div_lat = 20;
    @(negedge cpu_clk_75M);
    ex_div_req = 1'b1; ex_div_signed = 1'b0; ex_opdata1 = 32'd100; ex_opdata2 = 32'd7;
    #1;
    chk("t4_req_stall", stall_req, 64'd1);
    repeat (4) @(negedge cpu_clk_75M);
    @(negedge cpu_clk_75M);
    flush_i = 1'b1; ex_div_req = 1'b0;
    quiet = 1; stall_ok = 1; frz_ok = 1; rdy_n = -1; low_n = -1;
    for (int n = 6; n < BOUND; n++) begin
      @(negedge cpu_clk_75M);
      flush_i = 1'b0; ex_div_req = 1'b1; ex_opdata1 = 32'd9; ex_opdata2 = 32'd3;
      #1;
      if (hilo_we || div_err) quiet = 0;
      if (stall_req) stall_ok = 0;
      if (div_opdata1_o !== 32'd100) frz_ok = 0;
      if (div_ready_i && rdy_n < 0) rdy_n = n;
      if (!div_start) begin
        low_n = n;
        break;
      end
    end
    chk("t4_no_write", quiet, 64'd1);
    chk("t4_drain_stall", stall_ok, 64'd1);
    chk("t4_drain_ignore_req", frz_ok, 64'd1);
    chk("t4_start_fall", low_n, rdy_n + 1);
    chk("t4_drain_len", rdy_n, 64'd21);
    div_lat = 6;
    do_div(1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 1'b0, "t4_after");
    idle_cycles(1);

    // Back-to-back with the request held and operands toggling while BUSY.
    div_lat = 6;
    do_div(1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 1'b1, "t5a");
    do_div(1'b0, 32'd10, 32'd4, {32'd2, 32'd2}, 1'b1, "t5b");
    idle_cycles(2);

    for (int it = 0; it < 30; it++) begin
      bit s;
      logic [31:0] a, b;
      int lat;
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'd0;
        1:       b = $urandom_range(1, 15);
        default: b = $urandom;
      endcase
      lat = $urandom_range(1, 25);
      div_lat = lat;
      if ($urandom_range(0, 3) == 0)
        do_flush(s, a, b, $urandom_range(1, lat + 1), $sformatf("rnd%0d_flush", it));
      else
        do_div(s, a, b, ref_div(s, a, b), 1'($urandom_range(0, 1)), $sformatf("rnd%0d", it));
      idle_cycles($urandom_range(0, 2));
    end

    // Stuck divider: watchdog abort.
    div_stuck = 1;
    @(negedge cpu_clk_75M);
    ex_div_req = 1'b1; ex_div_signed = 1'b0; ex_opdata1 = 32'd20; ex_opdata2 = 32'd3;
    quiet = 1; stall_ok = 1; err_n = -1;
    for (int n = 1; n < BOUND; n++) begin
      @(negedge cpu_clk_75M);
      #1;
      if (hilo_we) quiet = 0;
      if (div_err) begin
        err_n = n;
        break;
      end
      if (!stall_req) stall_ok = 0;
    end
    chk("to_err_window", (err_n >= TIMEOUT) && (err_n <= TIMEOUT + 3), 64'd1);
    chk("to_no_write", quiet, 64'd1);
    chk("to_stall_held", stall_ok, 64'd1);
    @(negedge cpu_clk_75M);
    ex_div_req = 1'b0;
    #1;
    chk("to_err_pulse", div_err, 64'd0);
    chk("to_start_low", div_start, 64'd0);
    div_stuck = 0;
    do_reset();

    // Asynchronous reset in the middle of BUSY.
    div_lat = 5;
    do_div(1'b1, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD}, 1'b0, "pre_rst");
    idle_cycles(1);
    div_lat = 20;
    @(negedge cpu_clk_75M);
    ex_div_req = 1'b1; ex_div_signed = 1'b1; ex_opdata1 = 32'h12345678; ex_opdata2 = 32'd9;
    repeat (5) @(negedge cpu_clk_75M);
    #1;
    chk("rst_pre_busy", {div_start, stall_req}, 64'd3);
    #2;
    cpu_rst_n = 1'b0;
    #1;
    check_reset_vals("rst_mid");
    @(negedge cpu_clk_75M);
    ex_div_req = 1'b0;
    @(negedge cpu_clk_75M);
    cpu_rst_n = 1'b1;
    div_lat = 4;
    do_div(1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 1'b0, "post_rst");
    idle_cycles(1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
